// File: rtl/modular_multiplier.sv
// Sequential MSB-first interleaved modular multiplier: result = (a * b) mod p.
// Consumes one bit of b per cycle; start/done handshake with a fixed latency of N cycles.
module modular_multiplier #(
    parameter int N = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  p_reg, p_next;
    logic [N-1:0]  a_reg, a_next;
    logic [N-1:0]  b_reg, b_next;
    logic [N-1:0]  r_reg, r_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  result_reg, result_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    // One interleaved step. R < p keeps every intermediate inside N+1 bits.
    logic [N:0] p_ext;
    logic [N:0] t_dbl;
    logic [N:0] t_red;
    logic [N:0] u_sum;
    logic [N:0] u_red;

    always_comb begin
        p_ext = {1'b0, p_reg};
        t_dbl = {r_reg, 1'b0};
        t_red = (t_dbl >= p_ext) ? (t_dbl - p_ext) : t_dbl;
        u_sum = t_red + (b_reg[N-1] ? {1'b0, a_reg} : '0);
        u_red = (u_sum >= p_ext) ? (u_sum - p_ext) : u_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            p_reg      <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            r_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            p_reg      <= p_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            r_reg      <= r_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        p_next      = p_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        r_next      = r_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    p_next     = p;
                    a_next     = a;
                    b_next     = b;
                    r_next     = '0;
                    cnt_next   = CNT_LAST;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                r_next = u_red[N-1:0];
                b_next = b_reg << 1;
                if (cnt_reg == '0) begin
                    result_next = u_red[N-1:0];
                    done_next   = 1'b1;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign result = result_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_modular_multiplier.sv
// Scoreboard bench for modular_multiplier at N=8: expectations are queued at stimulus time
// and a negedge monitor pops and compares on every done pulse.
module tb_modular_multiplier;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] p = '0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [N-1:0] result;
    logic         busy;
    logic         done;

    modular_multiplier #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .p      (p),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [N-1:0] exp_q[$];
    int done_times[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_times.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got result %0d expected no done", result);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (result !== e) begin
                    bad++;
                    $display("FAIL result: got %0d expected %0d", result, e);
                end else begin
                    $display("result ok: %0d at cycle %0d", result, cyc);
                end
            end
        end
    end

    // Issues one operation and checks done latency, busy width and single done pulse.
    task automatic run_op(input logic [N-1:0] pp, input logic [N-1:0] aa,
                          input logic [N-1:0] bb, input logic [N-1:0] expected);
        int e0;
        int busy_cnt;
        int done_cnt;
        int done_lat;
        int guard;
        @(negedge clk);
        p = pp; a = aa; b = bb; start = 1'b1;
        exp_q.push_back(expected);
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
        // Operands are latched; disturbing them must not change the result.
        p = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
        busy_cnt = 0; done_cnt = 0; done_lat = -1; guard = 0;
        while (busy && guard < 100) begin
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_lat = cyc - e0;
            end
            guard++;
            @(negedge clk);
        end
        $display("op p=%0d a=%0d b=%0d expect=%0d latency=%0d busy=%0d", pp, aa, bb, expected, done_lat, busy_cnt);
        check("done_latency", 32'(done_lat), 32'(N));
        check("busy_cycles", 32'(busy_cnt), 32'(N + 1));
        check("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] r;
    } vec_t;

    vec_t vecs[] = '{
        '{8'd251, 8'd3,   8'd84,  8'd1},
        '{8'd251, 8'd250, 8'd255, 8'd247},
        '{8'd251, 8'd0,   8'd200, 8'd0},
        '{8'd251, 8'd200, 8'd0,   8'd0},
        '{8'd251, 8'd250, 8'd250, 8'd1},
        '{8'd251, 8'd100, 8'd3,   8'd49},
        '{8'd251, 8'd17,  8'd15,  8'd4},
        '{8'd2,   8'd1,   8'd255, 8'd1},
        '{8'd255, 8'd254, 8'd254, 8'd1},
        '{8'd13,  8'd12,  8'd13,  8'd0},
        '{8'd200, 8'd199, 8'd201, 8'd199},
        '{8'd7,   8'd5,   8'd6,   8'd2}
    };

    vec_t held[] = '{
        '{8'd251, 8'd3,   8'd84,  8'd1},
        '{8'd251, 8'd250, 8'd255, 8'd247},
        '{8'd251, 8'd100, 8'd3,   8'd49}
    };

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_result", 32'(result), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        foreach (vecs[i]) run_op(vecs[i].p, vecs[i].a, vecs[i].b, vecs[i].r);

        // Start held high: only inputs present at accept edges (every N+2 cycles) count.
        done_times.delete();
        for (int c = 0; c < 3 * (N + 2); c++) begin
            @(negedge clk);
            start = 1'b1;
            if (c % (N + 2) == 0) begin
                p = held[c / (N + 2)].p;
                a = held[c / (N + 2)].a;
                b = held[c / (N + 2)].b;
                exp_q.push_back(held[c / (N + 2)].r);
            end else begin
                a = 8'($urandom_range(250, 0));
                b = 8'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 40 && done_times.size() < 3; g++) @(negedge clk);
        check("held_done_count", 32'(done_times.size()), 32'd3);
        if (done_times.size() >= 3) begin
            check("held_spacing_1", 32'(done_times[1] - done_times[0]), 32'(N + 2));
            check("held_spacing_2", 32'(done_times[2] - done_times[1]), 32'(N + 2));
        end
        repeat (3) @(negedge clk);

        // Abort mid-RUN with reset: no done, outputs cleared.
        p = 8'd251; a = 8'd250; b = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        repeat (N + 4) @(negedge clk);
        run_op(8'd251, 8'd3, 8'd84, 8'd1);

        for (int g = 0; g < 40 && exp_q.size() != 0; g++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
